// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int          INSTR_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int          PC_STEP     = 4;

  typedef struct packed {
    logic [31:0]            pc;
    logic [INSTR_WIDTH-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order circular FIFO of fetched {pc, instruction} entries.
// Power-of-two depth so the pointers wrap without compare logic.
// Push while full is ignored unless a pop happens in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  fetch_entry_t               push_data,
  output fetch_entry_t               head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[head_q];
  assign pop_ok    = pop & ~empty;
  assign push_ok   = push & (~full | pop_ok);

  // Next-state pointers and occupancy; clear wins over push/pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop_ok)  head_d = head_q + 1'b1;
      if (push_ok) tail_d = tail_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // One storage slot per entry; reset contents give out_pc=0 / NOP on the head.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    fetch_entry_t slot_d;

    // Slot written only when it is the tail of an accepted push.
    always_comb begin
      slot_d = mem_q[gi];
      if (!clear && push_ok && (tail_q == PTR_W'(gi))) slot_d = push_data;
    end

    // Slot storage register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q[gi] <= '{pc: 32'h0, instruction: NOP_INSTR};
      end else begin
        mem_q[gi] <= slot_d;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: PC register driving a combinational ROM,
// fetch queue towards decode, and redirect handling that flushes the queue.
// Optional macro FETCH_MISALIGN_TRAP_EN adds a misaligned-redirect fault
// pulse and the captured faulting target.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2,
  parameter int          ADDR_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [ADDR_WIDTH-1:0]   rom_address,
  input  logic [INSTR_WIDTH-1:0]  rom_data,
  input  logic                    redirect_valid,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_WIDTH-1:0]   out_pc,
  output logic [INSTR_WIDTH-1:0]  out_instruction
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                    misaligned_fault,
  output logic [ADDR_WIDTH-1:0]   fault_pc
`endif
);

  logic [ADDR_WIDTH-1:0]      pc_q, pc_d;
  logic                       deq;
  logic                       enq;
  logic                       q_full;
  logic                       q_empty;
  logic [$clog2(QUEUE_DEPTH):0] q_count;
  fetch_entry_t               q_push_data;
  fetch_entry_t               q_head;

  assign rom_address     = pc_q;
  assign out_valid       = ~q_empty;
  assign out_pc          = ADDR_WIDTH'(q_head.pc);
  assign out_instruction = q_head.instruction;

  // Decode consumes the head even on a redirect cycle; the flush follows.
  assign deq = out_valid & out_ready;
  // Fetch only when there is (or will be) room; rom_data is dropped on redirect.
  assign enq = ~redirect_valid & (~q_full | deq);

  assign q_push_data = '{pc: 32'(pc_q), instruction: rom_data};

  // Next PC: aligned redirect target, sequential step on enqueue, else re-read.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~ADDR_WIDTH'(3);
    end else if (enq) begin
      pc_d = pc_q + ADDR_WIDTH'(PC_STEP);
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= ADDR_WIDTH'(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect_valid),
    .push      (enq),
    .pop       (deq),
    .push_data (q_push_data),
    .head_data (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  logic                  fault_q, fault_d;
  logic [ADDR_WIDTH-1:0] fault_pc_q, fault_pc_d;

  assign misaligned_fault = fault_q;
  assign fault_pc         = fault_pc_q;

  // Fault pulses for one cycle per misaligned redirect; target held until next.
  always_comb begin
    fault_d    = redirect_valid & (|redirect_pc[1:0]);
    fault_pc_d = fault_d ? redirect_pc : fault_pc_q;
  end

  // Fault registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end
`endif

  // Occupancy is internal to the queue; keep it visible for debug probes.
  logic q_count_unused;
  assign q_count_unused = ^q_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: table of per-cycle stimulus/expectations,
// a scoreboard of fetched entries, and hand-written reset sequences.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rom_address;
  logic [31:0] rom_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misaligned_fault;
  logic [31:0] fault_pc;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(logic [31:0] addr);
    if (addr == 32'h0) return 32'h0000_1137;
    if (addr == 32'h4) return 32'h3fc1_0113;
    return addr ^ 32'hC0DE_0000;
  endfunction

  assign rom_data = rom_word(rom_address);

  instruction_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (2),
    .ADDR_WIDTH  (32)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rom_address     (rom_address),
    .rom_data        (rom_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instruction (out_instruction)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misaligned_fault(misaligned_fault),
    .fault_pc        (fault_pc)
`endif
  );

  typedef struct {
    bit          rst_before;
    bit          ready;
    bit          redir;
    logic [31:0] rpc;
    bit          exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    bit          exp_fault;
    logic [31:0] exp_fault_pc;
  } vec_t;

  vec_t         vecs[$];
  fetch_entry_t sb[$];
  logic [31:0]  m_pc;

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(bit rb, bit rdy, bit rd, logic [31:0] rpc, bit ev,
                              logic [31:0] epc, logic [31:0] ea, bit ef,
                              logic [31:0] efp);
    vec_t v;
    v.rst_before = rb; v.ready = rdy; v.redir = rd; v.rpc = rpc;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_addr = ea;
    v.exp_fault = ef; v.exp_fault_pc = efp;
    vecs.push_back(v);
  endfunction

  task automatic check_reset_state(string tag);
    check32({tag, "_valid"}, 32'(out_valid), 32'd0);
    check32({tag, "_addr"}, rom_address, 32'h0);
    check32({tag, "_out_pc"}, out_pc, 32'h0);
    check32({tag, "_out_instr"}, out_instruction, NOP_INSTR);
`ifdef FETCH_MISALIGN_TRAP_EN
    check32({tag, "_fault"}, 32'(misaligned_fault), 32'd0);
    check32({tag, "_fault_pc"}, fault_pc, 32'h0);
`endif
    $display("[TB] %s: reset state checked", tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_state("reset");
    sb.delete();
    m_pc = 32'h0;
    rst_n = 1'b1;
  endtask

  // Drive one cycle's inputs, check outputs, advance the scoreboard model.
  task automatic apply(vec_t v, int idx);
    fetch_entry_t e;
    bit deq_m;
    out_ready = v.ready;
    redirect_valid = v.redir;
    redirect_pc = v.rpc;
    #1;
    check32($sformatf("v%0d_valid", idx), 32'(out_valid), 32'(v.exp_valid));
    check32($sformatf("v%0d_addr", idx), rom_address, v.exp_addr);
    check32($sformatf("v%0d_model_pc", idx), rom_address, m_pc);
    if (v.exp_valid) begin
      check32($sformatf("v%0d_out_pc", idx), out_pc, v.exp_pc);
      check32($sformatf("v%0d_out_instr", idx), out_instruction, rom_word(v.exp_pc));
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    check32($sformatf("v%0d_fault", idx), 32'(misaligned_fault), 32'(v.exp_fault));
    check32($sformatf("v%0d_fault_pc", idx), fault_pc, v.exp_fault_pc);
`endif
    check32($sformatf("v%0d_sb_valid", idx), 32'(out_valid), 32'(sb.size() != 0));
    deq_m = (sb.size() != 0) && v.ready;
    if (deq_m) begin
      e = sb.pop_front();
      check32($sformatf("v%0d_sb_pc", idx), out_pc, e.pc);
      check32($sformatf("v%0d_sb_instr", idx), out_instruction, e.instruction);
    end
    if (v.redir) begin
      sb.delete();
      m_pc = v.rpc & ~32'h3;
    end else if (sb.size() < 2) begin
      sb.push_back('{pc: m_pc, instruction: rom_word(m_pc)});
      m_pc = m_pc + 32'd4;
    end
    $display("[TB] cyc %0d rdy=%0b redir=%0b rpc=%h valid=%0b pc=%h instr=%h addr=%h",
             idx, v.ready, v.redir, v.rpc, out_valid, out_pc, out_instruction, rom_address);
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    // Streaming after reset: 1 per cycle, first word visible 1 cycle later.
    add(1, 1, 0, 0, 0, 32'h0,          32'h0,          0, 0);
    add(0, 1, 0, 0, 1, 32'h0,          32'h4,          0, 0);
    add(0, 1, 0, 0, 1, 32'h4,          32'h8,          0, 0);
    add(0, 1, 0, 0, 1, 32'h8,          32'hC,          0, 0);
    // Back-pressure from reset: queue fills, address parks at 8.
    add(1, 0, 0, 0, 0, 32'h0,          32'h0,          0, 0);
    add(0, 0, 0, 0, 1, 32'h0,          32'h4,          0, 0);
    add(0, 0, 0, 0, 1, 32'h0,          32'h8,          0, 0);
    add(0, 0, 0, 0, 1, 32'h0,          32'h8,          0, 0);
    add(0, 0, 0, 0, 1, 32'h0,          32'h8,          0, 0);
    add(0, 1, 0, 0, 1, 32'h0,          32'h8,          0, 0);
    add(0, 1, 0, 0, 1, 32'h4,          32'hC,          0, 0);
    add(0, 0, 0, 0, 1, 32'h8,          32'h10,         0, 0);
    // Redirect while holding 8/12: flush, refetch from 0x100.
    add(0, 0, 1, 32'h100, 1, 32'h8,    32'h10,         0, 0);
    add(0, 1, 0, 0, 0, 32'h0,          32'h100,        0, 0);
    add(0, 1, 0, 0, 1, 32'h100,        32'h104,        0, 0);
    // Redirect with a same-cycle dequeue, then wrap past 0xFFFF_FFFC.
    add(0, 1, 1, 32'hFFFF_FFF8, 1, 32'h104, 32'h108,   0, 0);
    add(0, 1, 0, 0, 0, 32'h0,          32'hFFFF_FFF8,  0, 0);
    add(0, 1, 0, 0, 1, 32'hFFFF_FFF8,  32'hFFFF_FFFC,  0, 0);
    add(0, 1, 0, 0, 1, 32'hFFFF_FFFC,  32'h0,          0, 0);
    add(0, 1, 0, 0, 1, 32'h0,          32'h4,          0, 0);
    // Misaligned redirect: fetch resumes at the aligned target.
    add(0, 1, 1, 32'h106, 1, 32'h4,    32'h8,          0, 0);
    add(0, 1, 0, 0, 0, 32'h0,          32'h104,        1, 32'h106);
    add(0, 1, 0, 0, 1, 32'h104,        32'h108,        0, 32'h106);

    @(negedge clk);
    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset();
      apply(vecs[i], i);
    end

    // Asynchronous reset between clock edges while the stream is active.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    @(negedge clk);
    sb.delete();
    m_pc = 32'h0;
    rst_n = 1'b1;
    v = '{rst_before: 0, ready: 1, redir: 0, rpc: 0, exp_valid: 0, exp_pc: 0,
          exp_addr: 32'h0, exp_fault: 0, exp_fault_pc: 0};
    apply(v, 100);
    v.exp_valid = 1; v.exp_pc = 32'h0; v.exp_addr = 32'h4;
    apply(v, 101);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
